// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
// The controller steps one 4-bit slice across the operands, LSB nibble first.
package cla_seq_pkg;

    localparam int unsigned NibW = 4;

    // The 2'b11 encoding is unused; the controller steers it back to StIdle.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    function automatic int unsigned nib_count(input int unsigned width);
        return width / NibW;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder with fully expanded carry terms.
module cla4_slice
    import cla_seq_pkg::*;
(
    input  logic [NibW-1:0] x,
    input  logic [NibW-1:0] y,
    input  logic            ci,
    output logic [NibW-1:0] s,
    output logic            co
);

    logic [NibW-1:0] g;
    logic [NibW-1:0] p;
    logic            c1;
    logic            c2;
    logic            c3;

    assign g = x & y;
    assign p = x ^ y;

    // Every carry is a flat sum of products of g, p and ci; nothing ripples.
    assign c1 = g[0]
              | (p[0] & ci);
    assign c2 = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & ci);
    assign c3 = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
    assign co = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit lookahead slice, one nibble per clock,
// with a start/busy/done handshake and fully registered outputs.
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned Nib  = nib_count(WIDTH);
    localparam int unsigned IdxW = (Nib > 1) ? $clog2(Nib) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Nib - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [NibW-1:0]   slice_x;
    logic [NibW-1:0]   slice_y;
    logic [NibW-1:0]   slice_s;
    logic              slice_co;
    logic [IdxW+1:0]   bit_off;

    assign bit_off = {idx_q, 2'b00};
    assign slice_x = a_q[bit_off +: NibW];
    assign slice_y = b_q[bit_off +: NibW];

    cla4_slice u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start && !busy_q) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[bit_off +: NibW] = slice_s;
                carry_d                = slice_co;
                if (idx_q == LastIdx) begin
                    // slice_s[3] is the final sum MSB on the last step.
                    cout_d  = slice_co;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[NibW-1] != a_q[WIDTH-1]);
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: a 16-bit instance for the main scenarios and a
// 4-bit instance for the single-nibble case.
module tb_cla_seq_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        busy4;
    logic        done4;
    logic [3:0]  sum4;
    logic        cout4;
    logic        ovf4;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(16)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    cla_seq_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4),
        .ovf   (ovf4)
    );

    function automatic exp_t model16(input logic [15:0] ma, input logic [15:0] mb,
                                     input logic mc);
        exp_t        e;
        logic [16:0] t;
        t      = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
        e.sum  = t[15:0];
        e.cout = t[16];
        e.ovf  = (ma[15] == mb[15]) && (t[15] != ma[15]);
        return e;
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic);
        a     = ia;
        b     = ib;
        cin   = ic;
        start = 1'b1;
        sb.push_back(model16(ia, ib, ic));
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic wait_done(output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        start  = 1'b0;
        start4 = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, sum, cout, ovf} !== 19'd0) begin
            n_err++;
            $display("FAIL reset16: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        n_cmp++;
        if ({busy4, done4, sum4, cout4, ovf4} !== 7'd0) begin
            n_err++;
            $display("FAIL reset4: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy4, done4, sum4, cout4, ovf4);
        end
    endtask

    task automatic test_basic;
        logic [15:0] va[4] = '{16'hFFFF, 16'h1234, 16'h7FFF, 16'h8000};
        logic [15:0] vb[4] = '{16'h0001, 16'h4321, 16'h0001, 16'h8000};
        logic        vc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int          cyc;
        bit          seen;
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], vc[i]);
            wait_done(cyc, seen);
            n_cmp++;
            if (!seen || cyc != 4) begin
                n_err++;
                $display("FAIL basic%0d_latency: got seen=%b cycles=%0d, want done after 4",
                         i, seen, cyc);
            end
            e = sb.pop_front();
            n_cmp++;
            if ({sum, cout, ovf, busy} !== {e.sum, e.cout, e.ovf, 1'b1}) begin
                n_err++;
                $display("FAIL basic%0d_result: got sum=%h cout=%b ovf=%b busy=%b, want %h %b %b 1",
                         i, sum, cout, ovf, busy, e.sum, e.cout, e.ovf);
            end
            @(negedge clk);
            n_cmp++;
            if ({done, busy} !== 2'b00 || sum !== e.sum) begin
                n_err++;
                $display("FAIL basic%0d_after: got done=%b busy=%b sum=%h, want 0 0 %h",
                         i, done, busy, sum, e.sum);
            end
        end
    endtask

    task automatic test_ignore_start;
        int   dones = 0;
        int   first = 0;
        exp_t e;
        issue(16'h1111, 16'h2222, 1'b0);
        e = sb.pop_front();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (first != 0 && k == first + 1) begin
                n_cmp++;
                if (busy !== 1'b0 || sum !== e.sum) begin
                    n_err++;
                    $display("FAIL ignore_after_done: got busy=%b sum=%h, want 0 %h",
                             busy, sum, e.sum);
                end
            end
            if (done === 1'b1) begin
                dones++;
                if (first == 0) first = k;
                n_cmp++;
                if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
                    n_err++;
                    $display("FAIL ignore_result: got sum=%h cout=%b ovf=%b, want %h %b %b",
                             sum, cout, ovf, e.sum, e.cout, e.ovf);
                end
                start = 1'b1;
                a     = 16'hFFFF;
                b     = 16'hFFFF;
            end else if (k <= 2) begin
                start = 1'b1;
                a     = 16'hAAAA;
                b     = 16'h5555;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (dones != 1 || first != 4) begin
            n_err++;
            $display("FAIL ignore_pulses: got dones=%0d at cycle %0d, want 1 at cycle 4",
                     dones, first);
        end
    endtask

    task automatic test_back_to_back;
        int   cyc;
        bit   seen;
        exp_t e;
        issue(16'h0F0F, 16'h00F1, 1'b1);
        wait_done(cyc, seen);
        e = sb.pop_front();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || sum !== e.sum) begin
            n_err++;
            $display("FAIL b2b_first: got busy=%b sum=%h, want 0 %h", busy, sum, e.sum);
        end
        issue(16'hC001, 16'hBFFF, 1'b0);
        n_cmp++;
        if (busy !== 1'b1 || sum !== 16'h0000) begin
            n_err++;
            $display("FAIL b2b_accept: got busy=%b sum=%h, want 1 0000", busy, sum);
        end
        wait_done(cyc, seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || cyc != 4 || {sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
            n_err++;
            $display("FAIL b2b_second: got seen=%b cyc=%0d sum=%h cout=%b ovf=%b, want 1 4 %h %b %b",
                     seen, cyc, sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int          cyc;
        bit          seen;
        int          stray = 0;
        exp_t        e;
        logic [15:0] part;
        issue(16'hABCD, 16'h1234, 1'b0);
        part = {12'd0, 4'(16'hABCD + 16'h1234)};
        @(negedge clk);
        n_cmp++;
        if (sum !== part || busy !== 1'b1) begin
            n_err++;
            $display("FAIL partial_sum: got sum=%h busy=%b, want %h 1", sum, busy, part);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        n_cmp++;
        if ({busy, done, sum, cout, ovf} !== 19'd0) begin
            n_err++;
            $display("FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL midrun_no_done: got %0d active cycles, want 0", stray);
        end
        issue(16'h8001, 16'h7FFF, 1'b1);
        wait_done(cyc, seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || cyc != 4 || {sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
            n_err++;
            $display("FAIL midrun_fresh: got seen=%b cyc=%0d sum=%h cout=%b ovf=%b, want 1 4 %h %b %b",
                     seen, cyc, sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_width4;
        logic [4:0] t;
        int         cyc = 0;
        bit         seen = 1'b0;
        a4     = 4'h9;
        b4     = 4'h8;
        cin4   = 1'b1;
        start4 = 1'b1;
        t      = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
        @(negedge clk);
        start4 = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done4 === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || cyc != 1) begin
            n_err++;
            $display("FAIL w4_latency: got seen=%b cycles=%0d, want done after 1", seen, cyc);
        end
        n_cmp++;
        if ({sum4, cout4, ovf4} !== {t[3:0], t[4], 1'b1}) begin
            n_err++;
            $display("FAIL w4_result: got sum=%h cout=%b ovf=%b, want %h %b 1",
                     sum4, cout4, ovf4, t[3:0], t[4]);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_width4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
